// File: rtl/bullet_pool_pkg.sv
// Shared projectile definitions: direction encoding and screen limits.
package bullet_pool_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned DEF_X_MAX = SCREEN_W - 1;
  localparam int unsigned DEF_Y_MAX = SCREEN_H - 1;

endpackage

// File: rtl/bullet_pool_slot.sv
// One bullet slot: holds act/x/y/dir, moves on tick, retires at the screen edge or on kill.
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned SPEED = 2,
  parameter int unsigned X_MAX = DEF_X_MAX,
  parameter int unsigned Y_MAX = DEF_Y_MAX
) (
  input  logic           clk25,
  input  logic           resetn,
  input  logic           tick,
  input  logic           kill,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic [1:0]     load_dir,
  output logic           act,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     dir
);

  logic           exit_c;
  logic [X_W-1:0] nx_c;
  logic [Y_W-1:0] ny_c;

  // Bounds are checked before the step so coordinates never wrap.
  always_comb begin
    exit_c = 1'b0;
    nx_c   = x;
    ny_c   = y;
    case (dir_e'(dir))
      DIR_UP: begin
        if (y < Y_W'(SPEED)) exit_c = 1'b1;
        else                 ny_c   = y - Y_W'(SPEED);
      end
      DIR_RIGHT: begin
        if (x > X_W'(X_MAX - SPEED)) exit_c = 1'b1;
        else                         nx_c   = x + X_W'(SPEED);
      end
      DIR_DOWN: begin
        if (y > Y_W'(Y_MAX - SPEED)) exit_c = 1'b1;
        else                         ny_c   = y + Y_W'(SPEED);
      end
      DIR_LEFT: begin
        if (x < X_W'(SPEED)) exit_c = 1'b1;
        else                 nx_c   = x - X_W'(SPEED);
      end
      default: exit_c = 1'b0;
    endcase
  end

  // Load only targets idle slots, so kill still beats movement for live bullets.
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      act <= 1'b0;
      x   <= '0;
      y   <= '0;
      dir <= '0;
    end else if (load) begin
      act <= 1'b1;
      x   <= load_x;
      y   <= load_y;
      dir <= load_dir;
    end else if (kill) begin
      act <= 1'b0;
    end else if (tick && act) begin
      if (exit_c) begin
        act <= 1'b0;
      end else begin
        x <= nx_c;
        y <= ny_c;
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Projectile engine: per-player fire edge detect, pending/cooldown, slot allocation and N_SLOTS bullets per player.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned N_SLOTS   = 4,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned X_MAX     = DEF_X_MAX,
  parameter int unsigned Y_MAX     = DEF_Y_MAX,
  parameter int unsigned COOLDOWN  = 8
) (
  input  logic                           clk25,
  input  logic                           resetn,
  input  logic                           frame_tick,
  input  logic [N_PLAYERS-1:0]           fire,
  input  logic [N_PLAYERS*X_W-1:0]       tank_x,
  input  logic [N_PLAYERS*Y_W-1:0]       tank_y,
  input  logic [N_PLAYERS*2-1:0]         tank_dir,
  input  logic [N_PLAYERS*N_SLOTS-1:0]   kill,
  output logic [N_PLAYERS*N_SLOTS-1:0]   bullet_act,
  output logic [N_PLAYERS*N_SLOTS*X_W-1:0] bullet_x,
  output logic [N_PLAYERS*N_SLOTS*Y_W-1:0] bullet_y,
  output logic [N_PLAYERS*N_SLOTS*2-1:0] bullet_dir,
  output logic [N_PLAYERS-1:0]           fire_ack,
  output logic [N_PLAYERS-1:0]           fire_drop
);

  localparam int unsigned NB   = N_PLAYERS * N_SLOTS;
  localparam int unsigned CD_W = $clog2(COOLDOWN + 1);

  logic [NB-1:0] load_c;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [N_SLOTS-1:0] free_c;
    logic [N_SLOTS-1:0] pick_c;
    logic [CD_W-1:0]    cd_q;
    logic [CD_W-1:0]    cd_next_c;
    logic               pend_q;
    logic               fire_q;
    logic               ack_q;
    logic               drop_q;
    logic               edge_c;
    logic               eval_c;

    // Free means idle at the start of the cycle; slots retired this cycle wait for the next tick.
    assign free_c    = ~bullet_act[p*N_SLOTS +: N_SLOTS];
    assign pick_c    = free_c & (~free_c + N_SLOTS'(1));
    assign edge_c    = fire[p] & ~fire_q;
    assign cd_next_c = (frame_tick && (cd_q != '0)) ? cd_q - CD_W'(1) : cd_q;
    assign eval_c    = frame_tick & pend_q & (cd_next_c == '0);

    assign load_c[p*N_SLOTS +: N_SLOTS] = eval_c ? pick_c : '0;
    assign fire_ack[p]  = ack_q;
    assign fire_drop[p] = drop_q;

    always_ff @(posedge clk25 or negedge resetn) begin
      if (!resetn) begin
        fire_q <= 1'b0;
        pend_q <= 1'b0;
        cd_q   <= '0;
        ack_q  <= 1'b0;
        drop_q <= 1'b0;
      end else begin
        fire_q <= fire[p];
        pend_q <= eval_c ? 1'b0 : (pend_q | edge_c);
        cd_q   <= (eval_c && (|free_c)) ? CD_W'(COOLDOWN) : cd_next_c;
        ack_q  <= eval_c & (|free_c);
        drop_q <= eval_c & ~(|free_c);
      end
    end
  end

  for (genvar s = 0; s < NB; s++) begin : g_slot
    localparam int unsigned P = s / N_SLOTS;

    bullet_pool_slot #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .SPEED (SPEED),
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
    ) u_slot (
      .clk25    (clk25),
      .resetn   (resetn),
      .tick     (frame_tick),
      .kill     (kill[s]),
      .load     (load_c[s]),
      .load_x   (tank_x[P*X_W +: X_W]),
      .load_y   (tank_y[P*Y_W +: Y_W]),
      .load_dir (tank_dir[P*2 +: 2]),
      .act      (bullet_act[s]),
      .x        (bullet_x[s*X_W +: X_W]),
      .y        (bullet_y[s*Y_W +: Y_W]),
      .dir      (bullet_dir[s*2 +: 2])
    );
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus randomized traffic against a behavioural model.
module tb_bullet_pool;

  localparam int NP = 2, NS = 4, NB = 8, XW = 10, YW = 9;
  localparam int SPEED = 2, XMAX = 639, YMAX = 479, CD = 8;

  logic              clk25 = 1'b0;
  logic              resetn;
  logic              frame_tick;
  logic [NP-1:0]     fire;
  logic [NP*XW-1:0]  tank_x;
  logic [NP*YW-1:0]  tank_y;
  logic [NP*2-1:0]   tank_dir;
  logic [NB-1:0]     kill;
  logic [NB-1:0]     bullet_act;
  logic [NB*XW-1:0]  bullet_x;
  logic [NB*YW-1:0]  bullet_y;
  logic [NB*2-1:0]   bullet_dir;
  logic [NP-1:0]     fire_ack;
  logic [NP-1:0]     fire_drop;

  always #5 clk25 = ~clk25;

  bullet_pool #(
    .N_PLAYERS(NP), .N_SLOTS(NS), .X_W(XW), .Y_W(YW), .SPEED(SPEED),
    .X_MAX(XMAX), .Y_MAX(YMAX), .COOLDOWN(CD)
  ) dut (
    .clk25(clk25), .resetn(resetn), .frame_tick(frame_tick), .fire(fire),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .kill(kill),
    .bullet_act(bullet_act), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_dir(bullet_dir), .fire_ack(fire_ack), .fire_drop(fire_drop)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_act[NB];
  int m_x[NB], m_y[NB], m_dir[NB];
  bit m_pend[NP], m_prev[NP], m_ack[NP], m_drop[NP];
  int m_cd[NP];

  int tx[NP], ty[NP], td[NP];
  int ack_seen[NP], drop_seen[NP], ack_tick[NP];
  int tick_no = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NB; s++) begin
      m_act[s] = 1'b0; m_x[s] = 0; m_y[s] = 0; m_dir[s] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      m_pend[p] = 1'b0; m_prev[p] = 1'b0; m_ack[p] = 1'b0; m_drop[p] = 1'b0; m_cd[p] = 0;
    end
  endtask

  task automatic clear_seen();
    for (int p = 0; p < NP; p++) begin
      ack_seen[p] = 0; drop_seen[p] = 0; ack_tick[p] = -1;
    end
  endtask

  // One clock cycle: drive, predict, clock, compare everything.
  task automatic step(input logic [NP-1:0] f, input logic tk, input logic [NB-1:0] kl);
    bit n_act[NB];
    int n_x[NB], n_y[NB], n_dir[NB];
    bit n_pend[NP], n_ack[NP], n_drop[NP];
    int n_cd[NP];
    fire = f; frame_tick = tk; kill = kl;
    for (int p = 0; p < NP; p++) begin
      tank_x[p*XW +: XW] = XW'(tx[p]);
      tank_y[p*YW +: YW] = YW'(ty[p]);
      tank_dir[p*2 +: 2] = 2'(td[p]);
    end
    n_act = m_act; n_x = m_x; n_y = m_y; n_dir = m_dir;
    n_pend = m_pend; n_cd = m_cd;
    for (int s = 0; s < NB; s++) begin
      if (m_act[s]) begin
        if (kl[s]) n_act[s] = 1'b0;
        else if (tk) begin
          case (m_dir[s])
            0: if (m_y[s] < SPEED) n_act[s] = 1'b0; else n_y[s] = m_y[s] - SPEED;
            1: if (m_x[s] > XMAX - SPEED) n_act[s] = 1'b0; else n_x[s] = m_x[s] + SPEED;
            2: if (m_y[s] > YMAX - SPEED) n_act[s] = 1'b0; else n_y[s] = m_y[s] + SPEED;
            default: if (m_x[s] < SPEED) n_act[s] = 1'b0; else n_x[s] = m_x[s] - SPEED;
          endcase
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      int cd;
      int slot;
      n_ack[p] = 1'b0; n_drop[p] = 1'b0;
      cd = m_cd[p];
      if (tk && cd > 0) cd = cd - 1;
      if (tk && m_pend[p] && cd == 0) begin
        slot = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_act[p*NS + i]) slot = p*NS + i;
        if (slot >= 0) begin
          n_act[slot] = 1'b1; n_x[slot] = tx[p]; n_y[slot] = ty[p]; n_dir[slot] = td[p];
          cd = CD; n_ack[p] = 1'b1;
        end else begin
          n_drop[p] = 1'b1;
        end
        n_pend[p] = 1'b0;
      end else if (f[p] && !m_prev[p]) begin
        n_pend[p] = 1'b1;
      end
      n_cd[p] = cd;
      m_prev[p] = f[p];
    end
    if (tk) tick_no++;
    @(posedge clk25);
    #1;
    m_act = n_act; m_x = n_x; m_y = n_y; m_dir = n_dir;
    m_pend = n_pend; m_cd = n_cd; m_ack = n_ack; m_drop = n_drop;
    for (int s = 0; s < NB; s++) begin
      check($sformatf("act%0d", s), bullet_act[s], m_act[s]);
      if (m_act[s]) begin
        check($sformatf("x%0d", s), bullet_x[s*XW +: XW], m_x[s]);
        check($sformatf("y%0d", s), bullet_y[s*YW +: YW], m_y[s]);
        check($sformatf("dir%0d", s), bullet_dir[s*2 +: 2], m_dir[s]);
      end
    end
    for (int p = 0; p < NP; p++) begin
      check($sformatf("ack%0d", p), fire_ack[p], m_ack[p]);
      check($sformatf("drop%0d", p), fire_drop[p], m_drop[p]);
      if (fire_ack[p]) begin ack_seen[p]++; ack_tick[p] = tick_no; end
      if (fire_drop[p]) drop_seen[p]++;
    end
    @(negedge clk25);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step('0, 1'b1, '0);
      step('0, 1'b0, '0);
    end
  endtask

  task automatic fire_pulse(input logic [NP-1:0] f);
    step(f, 1'b0, '0);
    step('0, 1'b0, '0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; fire = '0; frame_tick = 1'b0; kill = '0;
    repeat (2) @(negedge clk25);
    model_reset();
    clear_seen();
    resetn = 1'b1;
    @(negedge clk25);
    check("rst_act", bullet_act, 0);
    check("rst_ack", fire_ack, 0);
    check("rst_drop", fire_drop, 0);
  endtask

  task automatic set_tank(input int p, input int x, input int y, input int d);
    tx[p] = x; ty[p] = y; td[p] = d;
  endtask

  initial begin
    int t0;
    resetn = 1'b0; fire = '0; frame_tick = 1'b0; kill = '0;
    tank_x = '0; tank_y = '0; tank_dir = '0;
    for (int p = 0; p < NP; p++) set_tank(p, 0, 0, 0);
    @(negedge clk25);

    // T1: spawn at (60,60) heading right, then three moves
    do_reset();
    set_tank(0, 60, 60, 1);
    fire_pulse(2'b01);
    step('0, 1'b1, '0);
    check("t1_act0", bullet_act[0], 1);
    check("t1_x0", bullet_x[0 +: XW], 60);
    check("t1_y0", bullet_y[0 +: YW], 60);
    ticks(3);
    check("t1_x0_moved", bullet_x[0 +: XW], 66);
    check("t1_acks", ack_seen[0], 1);

    // T2: retire at top edge and at right edge without wrapping
    do_reset();
    set_tank(0, 100, 1, 0);
    fire_pulse(2'b01);
    step('0, 1'b1, '0);
    check("t2_up_spawn", bullet_act[0], 1);
    step('0, 1'b1, '0);
    check("t2_up_retired", bullet_act[0], 0);
    check("t2_up_nowrap", bullet_y[0 +: YW], 1);
    do_reset();
    set_tank(0, 638, 50, 1);
    fire_pulse(2'b01);
    step('0, 1'b1, '0);
    step('0, 1'b1, '0);
    check("t2_right_retired", bullet_act[0], 0);
    check("t2_right_nowrap", bullet_x[0 +: XW], 638);

    // T3: five edges on player 1 fill slots 4..7, fifth drops
    do_reset();
    set_tank(1, 320, 240, 3);
    for (int k = 0; k < 5; k++) begin
      fire_pulse(2'b10);
      ticks(CD);
      if (k < 4) check($sformatf("t3_fill%0d", k), bullet_act[7:4], (1 << (k + 1)) - 1);
    end
    check("t3_full", bullet_act[7:4], 15);
    check("t3_acks", ack_seen[1], 4);
    check("t3_drops", drop_seen[1], 1);

    // T4: edge during cooldown is held and spawns on the 8th tick
    do_reset();
    set_tank(0, 100, 200, 1);
    fire_pulse(2'b01);
    step('0, 1'b1, '0);
    t0 = ack_tick[0];
    ticks(2);
    fire_pulse(2'b01);
    ticks(10);
    check("t4_acks", ack_seen[0], 2);
    check("t4_spacing", ack_tick[0] - t0, CD);

    // T5: kill of slot 0 on the spawn tick does not free it for reuse
    do_reset();
    set_tank(0, 320, 240, 1);
    for (int k = 0; k < 4; k++) begin
      fire_pulse(2'b01);
      ticks(CD);
    end
    check("t5_full", bullet_act[3:0], 15);
    fire_pulse(2'b01);
    step('0, 1'b1, 8'h01);
    check("t5_drop", fire_drop[0], 1);
    check("t5_killed", bullet_act[0], 0);
    ticks(2);
    check("t5_noreuse", bullet_act[0], 0);
    check("t5_acks", ack_seen[0], 4);

    // T6: asynchronous reset with six bullets in flight
    do_reset();
    set_tank(0, 200, 100, 2);
    set_tank(1, 400, 300, 0);
    for (int k = 0; k < 3; k++) begin
      fire_pulse(2'b11);
      ticks(CD);
    end
    check("t6_six", bullet_act, 8'h77);
    fire_pulse(2'b11);
    #2 resetn = 1'b0;
    #1 check("t6_async_clear", bullet_act, 0);
    repeat (2) @(negedge clk25);
    model_reset();
    clear_seen();
    resetn = 1'b1;
    @(negedge clk25);
    ticks(10);
    check("t6_no_ack", ack_seen[0] + ack_seen[1], 0);
    check("t6_idle", bullet_act, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NP-1:0] f;
      logic [NB-1:0] kl;
      logic tk;
      f = fire;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 9) == 0) f[p] = ~f[p];
        if ($urandom_range(0, 19) == 0)
          set_tank(p, int'($urandom_range(0, XMAX)), int'($urandom_range(0, YMAX)),
                   int'($urandom_range(0, 3)));
      end
      tk = ($urandom_range(0, 3) == 0);
      kl = '0;
      for (int s = 0; s < NB; s++) kl[s] = m_act[s] && ($urandom_range(0, 15) == 0);
      step(f, tk, kl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
